// File: rtl/dcache_responder.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache
// with zero-latency read hits and a single outstanding backing-memory request.
module dcache_responder #(
  parameter int LINES = 16
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_reset,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_wdata,
  input  logic        dcache_en,
  input  logic        dcache_wr,
  output logic [31:0] dcache_rdata,
  output logic        dcache_rdy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RFILL = 2'd1,
    WTHRU = 2'd2,
    WDONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [29:0]      req_addr_p0;
  logic [31:0]      req_wdata_p0;

  logic [IDX_W-1:0] cur_idx, req_idx;
  logic [TAG_W-1:0] cur_tag, req_tag;
  logic             cur_hit, req_hit;
  logic             latch_req, fill_we, wr_upd;

  // Byte offset within the word carries no information for a word cache.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^dcache_addr[1:0];

  assign cur_idx = dcache_addr[2 +: IDX_W];
  assign cur_tag = dcache_addr[31 -: TAG_W];
  assign req_idx = req_addr_p0[IDX_W-1:0];
  assign req_tag = req_addr_p0[29 -: TAG_W];

  assign cur_hit = valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);
  assign req_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  assign dcache_rdata = data_mem[cur_idx];
  assign mem_addr     = {req_addr_p0, 2'b00};
  assign mem_wdata    = req_wdata_p0;

  always_comb begin
    state_nxt  = state;
    dcache_rdy = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    latch_req  = 1'b0;
    fill_we    = 1'b0;
    wr_upd     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!dcache_en) begin
          dcache_rdy = 1'b1;
        end else if (dcache_wr) begin
          latch_req = 1'b1;
          state_nxt = WTHRU;
        end else if (cur_hit) begin
          dcache_rdy = 1'b1;
        end else begin
          latch_req = 1'b1;
          state_nxt = RFILL;
        end
      end
      RFILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          fill_we   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WTHRU: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          wr_upd    = req_hit;
          state_nxt = WDONE;
        end
      end
      WDONE: begin
        dcache_rdy = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM and valid bits, cleared asynchronously.
  always_ff @(posedge ctrl_clk or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state   <= IDLE;
      valid_q <= '0;
    end else begin
      state <= state_nxt;
      if (fill_we) valid_q[req_idx] <= 1'b1;
    end
  end

  // Request capture and line storage; request is frozen for the whole memory transaction.
  always_ff @(posedge ctrl_clk) begin
    if (latch_req) begin
      req_addr_p0  <= dcache_addr[31:2];
      req_wdata_p0 <= dcache_wdata;
    end
    if (fill_we) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= mem_rdata;
    end else if (wr_upd) begin
      data_mem[req_idx] <= req_wdata_p0;
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Randomized bench for dcache_responder against a word-level memory and
// line-ownership reference model.
module tb_dcache_responder;

  localparam int LINES = 16;

  logic        ctrl_clk = 1'b0;
  logic        ctrl_reset;
  logic [31:0] dcache_addr, dcache_wdata, dcache_rdata;
  logic        dcache_en, dcache_wr, dcache_rdy;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_pass = 0;
  bit stray_en = 1'b0;

  logic [31:0] mem_model [logic [29:0]];
  bit          ref_valid [LINES];
  logic [29:0] ref_word  [LINES];

  dcache_responder #(.LINES(LINES)) dut (
    .ctrl_clk     (ctrl_clk),
    .ctrl_reset   (ctrl_reset),
    .dcache_addr  (dcache_addr),
    .dcache_wdata (dcache_wdata),
    .dcache_en    (dcache_en),
    .dcache_wr    (dcache_wr),
    .dcache_rdata (dcache_rdata),
    .dcache_rdy   (dcache_rdy),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  initial forever #5 ctrl_clk = ~ctrl_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  function automatic logic [31:0] memval(input logic [29:0] w);
    if (mem_model.exists(w)) return mem_model[w];
    return {w, 2'b01} ^ 32'hA5C3_0F96;
  endfunction

  function automatic bit ref_hit(input logic [29:0] w);
    int idx = int'(w) % LINES;
    return ref_valid[idx] && (ref_word[idx] == w);
  endfunction

  function automatic void ref_clear();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
  endfunction

  // Caller is just after a falling edge; returns just after a falling edge with en low.
  task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input int lat, input string nm);
    logic [29:0] w = a[31:2];
    bit          hit = ref_hit(w);
    int cyc = 0, low = 0, rc = 0, req_tot = 0, nrd = 0, nwr = 0;
    bit done = 1'b0;
    logic [31:0] rd = '0;
    dcache_en = 1'b1; dcache_wr = wr; dcache_addr = a; dcache_wdata = wd;
    while (!done && cyc < 40) begin
      mem_ack = 1'b0;
      #1;
      if (mem_req) begin
        req_tot++; rc++;
        if (rc == lat) begin
          rc = 0; mem_ack = 1'b1;
          chk({nm, "_maddr"}, mem_addr, {a[31:2], 2'b00});
          if (mem_we) begin
            nwr++;
            chk({nm, "_mwdata"}, mem_wdata, wd);
            mem_model[w] = wd;
          end else begin
            nrd++;
            mem_rdata = memval(w);
          end
        end
      end else if (stray_en && $urandom_range(0, 3) == 0) begin
        mem_ack = 1'b1;
        mem_rdata = $urandom;
      end
      #1;
      if (dcache_rdy) begin
        done = 1'b1;
        rd = dcache_rdata;
      end else begin
        low++;
      end
      cyc++;
      @(negedge ctrl_clk);
    end
    dcache_en = 1'b0; mem_ack = 1'b0;
    chk({nm, "_done"}, 32'(done), 32'd1);
    if (wr) begin
      chk({nm, "_lowcyc"}, low, lat + 1);
      chk({nm, "_nwr"}, nwr, 1);
      chk({nm, "_nrd"}, nrd, 0);
    end else if (hit) begin
      chk({nm, "_lowcyc"}, low, 0);
      chk({nm, "_reqcyc"}, req_tot, 0);
      chk({nm, "_rdata"}, rd, memval(w));
    end else begin
      chk({nm, "_lowcyc"}, low, lat + 1);
      chk({nm, "_nrd"}, nrd, 1);
      chk({nm, "_nwr"}, nwr, 0);
      chk({nm, "_rdata"}, rd, memval(w));
      ref_valid[int'(w) % LINES] = 1'b1;
      ref_word[int'(w) % LINES]  = w;
    end
  endtask

  task automatic idle_cycles(input int n, input string nm);
    int bad_rdy = 0, bad_req = 0;
    dcache_en = 1'b0;
    repeat (n) begin
      #2;
      if (dcache_rdy !== 1'b1) bad_rdy++;
      if (mem_req !== 1'b0) bad_req++;
      @(negedge ctrl_clk);
    end
    chk({nm, "_rdy"}, bad_rdy, 0);
    chk({nm, "_mreq"}, bad_req, 0);
  endtask

  task automatic rst_mid_fill(input logic [31:0] a);
    logic pre;
    dcache_en = 1'b1; dcache_wr = 1'b0; dcache_addr = a; mem_ack = 1'b0;
    @(negedge ctrl_clk);
    @(negedge ctrl_clk);
    #1 pre = mem_req;
    #1 ctrl_reset = 1'b0;
    #1 chk("rst_mreq_async", mem_req, 1'b0);
    @(negedge ctrl_clk);
    #1 chk("rst_mreq_hold", mem_req, 1'b0);
    chk("rst_mwe_hold", mem_we, 1'b0);
    dcache_en = 1'b0;
    ctrl_reset = 1'b1;
    ref_clear();
    chk("rst_pre_req", pre, 1'b1);
    @(negedge ctrl_clk);
  endtask

  initial begin
    ctrl_reset = 1'b0;
    dcache_en = 1'b0; dcache_wr = 1'b0; dcache_addr = '0; dcache_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    ref_clear();
    #3;
    chk("reset_mreq", mem_req, 1'b0);
    chk("reset_mwe", mem_we, 1'b0);
    chk("reset_rdy", dcache_rdy, 1'b1);
    @(negedge ctrl_clk);
    @(negedge ctrl_clk);
    ctrl_reset = 1'b1;
    @(negedge ctrl_clk);

    idle_cycles(10, "idle10");

    mem_model[30'h40] = 32'hDEAD_BEEF;
    do_access(1'b0, 32'h100, 32'h0, 3, "cold_rd");
    do_access(1'b0, 32'h100, 32'h0, 3, "rehit_rd");

    do_access(1'b1, 32'h100, 32'h1234_5678, 2, "st_hit");
    do_access(1'b0, 32'h100, 32'h0, 2, "ld_after_st");

    do_access(1'b1, 32'h200, 32'hCAFE_F00D, 1, "st_nalloc");
    do_access(1'b0, 32'h200, 32'h0, 2, "ld_nalloc");

    do_access(1'b0, 32'h000, 32'h0, 2, "conf_a");
    do_access(1'b0, 32'h040, 32'h0, 3, "conf_b");
    do_access(1'b0, 32'h000, 32'h0, 1, "conf_a2");

    rst_mid_fill(32'h300);
    idle_cycles(3, "post_rst");
    do_access(1'b0, 32'h300, 32'h0, 2, "rst_reread");
    do_access(1'b0, 32'h200, 32'h0, 2, "rst_cold");

    stray_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [25:0] tg;
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0: tg = 26'd0;
        1: tg = 26'd1;
        2: tg = 26'd5;
        default: tg = 26'h3FF_FFFF;
      endcase
      a = {tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      do_access($urandom_range(0, 9) < 3, a, $urandom, $urandom_range(1, 4), "rnd");
      if ($urandom_range(0, 7) == 0) idle_cycles(1, "rnd_idle");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
